// File: rtl/pla_newt_shift_issue.sv
// Serial right shifter that issues one 1-bit shift step per cycle to a downstream decoder.
// Latency: max(amount,1)+1 cycles from accept to done, plus one cycle per stalled step.
// Backpressure: req_ready only in IDLE; cpipe_stall=1 freezes the current step and all state.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (accepted only in IDLE)
//   req_arith, req_amount, req_data shift type, distance (0..31), operand
//   cpipe, cpipe_valid, cpipe_stall control word per step, live flag, downstream hold
//   ai_out                          pre-shift working value presented with each step
//   done, result                    one-cycle completion pulse, final value (held until next accept)
module pla_newt_shift_issue #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_arith,
    input  logic [AMT_W-1:0]  req_amount,
    input  logic [DATA_W-1:0] req_data,
    output logic [7:0]        cpipe,
    output logic              cpipe_valid,
    input  logic              cpipe_stall,
    output logic [DATA_W-1:0] ai_out,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    // Control-pipe words. Bits 7 and 5 always set; bit 6 selects pass-through,
    // bit 1 selects sign fill.
    localparam logic [7:0] CW_NOP  = 8'h00;
    localparam logic [7:0] CW_PASS = 8'hE2;
    localparam logic [7:0] CW_SRL1 = 8'hA0;
    localparam logic [7:0] CW_SRA1 = 8'hA2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] work_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic [AMT_W-1:0]  remaining;
    logic [AMT_W-1:0]  remaining_nxt;
    logic              arith_q;
    logic              arith_nxt;
    logic              pass_q;      // captured amount was zero: single pass-through step
    logic              pass_nxt;

    logic              accept;
    logic              step_done;
    logic [DATA_W-1:0] work_shifted;
    logic              fill_bit;

    assign accept    = req_valid && req_ready;
    assign step_done = (state == ST_ISSUE) && !cpipe_stall;

    // Sign fill only for arithmetic shifts; the pass step leaves the value untouched.
    assign fill_bit     = arith_q & work[DATA_W-1];
    assign work_shifted = pass_q ? work : {fill_bit, work[DATA_W-1:1]};

    // Outputs are decoded from registered state so reset clears them immediately.
    always_comb begin
        req_ready   = 1'b0;
        cpipe_valid = 1'b0;
        cpipe       = CW_NOP;
        ai_out      = '0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_ISSUE: begin
                cpipe_valid = 1'b1;
                ai_out      = work;
                if (pass_q) begin
                    cpipe = CW_PASS;
                end else if (arith_q) begin
                    cpipe = CW_SRA1;
                end else begin
                    cpipe = CW_SRL1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        remaining_nxt = remaining;
        arith_nxt     = arith_q;
        pass_nxt      = pass_q;
        result_nxt    = result;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    work_nxt  = req_data;
                    arith_nxt = req_arith;
                    pass_nxt  = (req_amount == '0);
                    // A zero-distance request still issues one (pass) step.
                    remaining_nxt = (req_amount == '0) ? AMT_W'(1) : req_amount;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (step_done) begin
                    work_nxt      = work_shifted;
                    remaining_nxt = remaining - AMT_W'(1);
                    if (remaining == AMT_W'(1)) begin
                        result_nxt = work_shifted;
                        state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            remaining <= '0;
            arith_q   <= 1'b0;
            pass_q    <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            remaining <= remaining_nxt;
            arith_q   <= arith_nxt;
            pass_q    <= pass_nxt;
            result    <= result_nxt;
        end
    end

endmodule

// File: tb/tb_pla_newt_shift_issue.sv
module tb_pla_newt_shift_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_arith = 1'b0;
    logic [4:0]  req_amount = '0;
    logic [31:0] req_data = '0;
    logic [7:0]  cpipe;
    logic        cpipe_valid;
    logic        cpipe_stall = 1'b0;
    logic [31:0] ai_out;
    logic        done;
    logic [31:0] result;

    pla_newt_shift_issue #(.DATA_W(32), .AMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_arith  (req_arith),
        .req_amount (req_amount),
        .req_data   (req_data),
        .cpipe      (cpipe),
        .cpipe_valid(cpipe_valid),
        .cpipe_stall(cpipe_stall),
        .ai_out     (ai_out),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = -100;
    logic prev_done = 1'b0;

    logic [39:0] step_q[$];   // {cpipe, ai_out}
    logic [31:0] res_q[$];
    int          lat_q[$];
    int          acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected steps for a full operation; final result and latency are hand-computed.
    task automatic push_op(input logic arith, input int amt, input logic [31:0] data,
                           input logic [31:0] res, input int lat);
        logic [31:0] w;
        w = data;
        if (amt == 0) begin
            step_q.push_back({8'hE2, w});
        end else begin
            for (int i = 0; i < amt; i++) begin
                step_q.push_back({(arith ? 8'hA2 : 8'hA0), w});
                w = {(arith & w[31]), w[31:1]};
            end
        end
        res_q.push_back(res);
        lat_q.push_back(lat);
    endtask

    // Monitor: sample at negedge, pop and compare against the scoreboard.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                continue;
            end
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (cpipe_valid) begin
                if (step_q.size() == 0) begin
                    check("unexpected_step", {24'h0, cpipe}, 32'h0);
                end else begin
                    e = step_q[0];
                    check("cpipe", {24'h0, cpipe}, {24'h0, e[39:32]});
                    check("ai_out", ai_out, e[31:0]);
                    if (!cpipe_stall) void'(step_q.pop_front());
                end
            end
            if (done) begin
                check("done_width", {31'h0, prev_done}, 32'h0);
                if (res_q.size() == 0) begin
                    check("unexpected_done", result, 32'hDEADDEAD);
                end else begin
                    check("result", result, res_q.pop_front());
                end
                if (acc_q.size() > 0 && lat_q.size() > 0) begin
                    check("latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
                end else begin
                    check("latency_missing", 32'(acc_q.size()), 32'(lat_q.size() + 1));
                end
                last_done_cyc = cyc;
            end
            prev_done = done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpipe"}, {24'h0, cpipe}, 32'h0);
        check({tag, "_cpipe_valid"}, {31'h0, cpipe_valid}, 32'h0);
        check({tag, "_ai_out"}, ai_out, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_result"}, result, 32'h0);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    // Present a request and wait until it is accepted; returns at accept edge + 1.
    task automatic issue(input logic arith, input logic [4:0] amt, input logic [31:0] data);
        int budget;
        req_arith  = arith;
        req_amount = amt;
        req_data   = data;
        req_valid  = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!req_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                check("accept_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((step_q.size() != 0 || res_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) check("drain_timeout", 32'(step_q.size() + res_q.size()), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        // Reset state, checked while reset is held.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Amount 0: one PASS step.
        push_op(1'b0, 0, 32'h12345678, 32'h12345678, 2);
        issue(1'b0, 5'd0, 32'h12345678);
        wait_drain();

        // Logical shift by 4.
        push_op(1'b0, 4, 32'h80000000, 32'h08000000, 5);
        issue(1'b0, 5'd4, 32'h80000000);
        wait_drain();

        // Arithmetic shift by 3.
        push_op(1'b1, 3, 32'h80000010, 32'hF0000002, 4);
        issue(1'b1, 5'd3, 32'h80000010);
        wait_drain();

        // Stall the first step for three cycles.
        push_op(1'b0, 2, 32'hC0000000, 32'h30000000, 6);
        issue(1'b0, 5'd2, 32'hC0000000);
        cpipe_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cpipe_stall = 1'b0;
        wait_drain();

        // Amount 31 arithmetic, reset during the 10th step.
        for (int i = 0; i < 9; i++) begin
            step_q.push_back({8'hA2, 32'($signed(32'h80000000) >>> i)});
        end
        issue(1'b1, 5'd31, 32'h80000000);
        repeat (9) @(posedge clk);
        #1;
        check("abort_steps_seen", 32'(step_q.size()), 32'h0);
        check("abort_in_issue", {31'h0, cpipe_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        step_q.delete();
        acc_q.delete();
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        check("abort_no_done", {31'h0, done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After release: full amount-31 operations.
        push_op(1'b1, 31, 32'h80000000, 32'hFFFFFFFF, 32);
        issue(1'b1, 5'd31, 32'h80000000);
        wait_drain();
        push_op(1'b0, 31, 32'h80000000, 32'h00000001, 32);
        issue(1'b0, 5'd31, 32'h80000000);
        wait_drain();

        // Continuously valid requests: second accepted on first IDLE after DONE.
        push_op(1'b0, 1, 32'h00000003, 32'h00000001, 2);
        issue(1'b0, 5'd1, 32'h00000003);
        req_valid  = 1'b1;
        req_arith  = 1'b1;
        req_amount = 5'd2;
        req_data   = 32'hFFFFFFF0;
        push_op(1'b1, 2, 32'hFFFFFFF0, 32'hFFFFFFFC, 3);
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("b2b_accept_gap", 32'(cyc - last_done_cyc), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain();

        check("leftover_steps", 32'(step_q.size()), 32'h0);
        check("leftover_results", 32'(res_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
